// File: rtl/iob_cpu_bus_merge_pkg.sv
// Shared types and width helpers for the CPU bus merge.
// Request layout is {valid, addr, wdata, wstrb}; response layout is {rdata, ready}.
package iob_cpu_bus_merge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } state_t;

  localparam int MST_I = 0;
  localparam int MST_D = 1;

  function automatic int req_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  function automatic int resp_width(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/iob_cpu_bus_merge_arb.sv
// Two-input round-robin grant with a last-served register and a one-hot output.
// On a tie the master that was not served last wins; the history resets to master 0.
module iob_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       done_id,
  output logic [1:0] gnt
);

  logic last_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= 1'b0;
    end else if (done) begin
      last_gnt <= done_id;
    end
  end

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/iob_cpu_bus_merge.sv
// Merges the CPU instruction and data iob buses onto one memory port:
// registered round-robin grant, one transaction in flight, response watchdog.
module iob_cpu_bus_merge
  import iob_cpu_bus_merge_pkg::*;
#(
  parameter  int ADDR_W    = 32,
  parameter  int DATA_W    = 32,
  parameter  int TIMEOUT_W = 8,
  localparam int REQ_W     = req_width(ADDR_W, DATA_W),
  localparam int RESP_W    = resp_width(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REQ_W-1:0]  ibus_req,
  output logic [RESP_W-1:0] ibus_resp,
  input  logic [REQ_W-1:0]  dbus_req,
  output logic [RESP_W-1:0] dbus_resp,
  output logic [REQ_W-1:0]  mem_req,
  input  logic [RESP_W-1:0] mem_resp,
  output logic              timeout
);

  // Handshake: a master holds valid and its fields until it sees ready=1 for
  // one cycle; the slave answers with a single-cycle ready pulse, possibly in
  // the same cycle mem valid rises.

  state_t                state, state_nxt;
  logic [TIMEOUT_W-1:0]  wdog_cnt;
  logic [1:0]            arb_gnt;
  logic                  mem_ready;
  logic [DATA_W-1:0]     mem_rdata;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  granted;
  logic                  wdog_hit;
  logic                  done;
  logic                  done_id;
  logic                  ibus_ready;
  logic                  dbus_ready;

  assign mem_ready = mem_resp[0];
  assign mem_rdata = mem_resp[RESP_W-1:1];
  assign granted   = (state != ST_IDLE);
  // A real response in the final watchdog cycle takes priority over the abort.
  assign wdog_hit  = granted && !mem_ready && (wdog_cnt == '1);
  assign done      = granted && (mem_ready || wdog_hit);
  assign done_id   = (state == ST_GNT_D);

  iob_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({dbus_req[REQ_W-1], ibus_req[REQ_W-1]}),
    .done    (done),
    .done_id (done_id),
    .gnt     (arb_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Held at zero while idle so every grant starts a fresh count.
  always_ff @(posedge clk) begin
    if (rst || state == ST_IDLE) begin
      wdog_cnt <= '0;
    end else if (!mem_ready) begin
      wdog_cnt <= wdog_cnt + TIMEOUT_W'(1);
    end
  end

  always_comb begin
    state_nxt  = state;
    mem_req    = '0;
    ibus_ready = 1'b0;
    dbus_ready = 1'b0;
    timeout    = wdog_hit;
    resp_rdata = wdog_hit ? '0 : mem_rdata;
    case (state)
      ST_IDLE: begin
        if (arb_gnt[MST_D]) begin
          state_nxt = ST_GNT_D;
        end else if (arb_gnt[MST_I]) begin
          state_nxt = ST_GNT_I;
        end
      end
      ST_GNT_I: begin
        mem_req = ibus_req;
        if (wdog_hit) mem_req[REQ_W-1] = 1'b0;
        ibus_ready = done;
        if (done) state_nxt = ST_IDLE;
      end
      ST_GNT_D: begin
        mem_req = dbus_req;
        if (wdog_hit) mem_req[REQ_W-1] = 1'b0;
        dbus_ready = done;
        if (done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign ibus_resp = {resp_rdata, ibus_ready};
  assign dbus_resp = {resp_rdata, dbus_ready};

endmodule
